// File: rtl/e203_dtcm_icb_ctrl.sv
// ICB-to-SRAM controller for the DTCM macro: single-beat reads/writes,
// 2-entry response buffer and idle-driven light-sleep control.
module e203_dtcm_icb_ctrl #(
  parameter int AW      = 16,
  parameter int DW      = 32,
  parameter int MW      = 4,
  parameter int RAM_AW  = 14,
  parameter int DP      = 16384,
  parameter int LS_IDLE = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_icb_cmd_valid,
  output logic              i_icb_cmd_ready,
  input  logic [AW-1:0]     i_icb_cmd_addr,
  input  logic              i_icb_cmd_read,
  input  logic [DW-1:0]     i_icb_cmd_wdata,
  input  logic [MW-1:0]     i_icb_cmd_wmask,
  output logic              i_icb_rsp_valid,
  input  logic              i_icb_rsp_ready,
  output logic [DW-1:0]     i_icb_rsp_rdata,
  output logic              i_icb_rsp_err,
  output logic              ram_sd,
  output logic              ram_ds,
  output logic              ram_ls,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [MW-1:0]     ram_wem,
  output logic [DW-1:0]     ram_din,
  input  logic [DW-1:0]     ram_dout
);

  localparam int CW = (LS_IDLE > 0) ? $clog2(LS_IDLE + 1) : 1;
  localparam logic [CW-1:0] LS_MAX = CW'(LS_IDLE);
  localparam logic [RAM_AW:0] DP_LIM = (RAM_AW + 1)'(DP);

  logic [1:0]        occ;
  logic              accept;
  logic              rsp_hs;
  logic              in_range;
  logic              idle;
  logic [RAM_AW-1:0] word;
  logic              unused;

  logic              pend;
  logic              pend_rd;
  logic              pend_err;
  logic [DW-1:0]     pend_data;

  logic [DW:0]       rbuf [2];
  logic              wptr;
  logic              rptr;
  logic [1:0]        buf_cnt;
  logic              push;
  logic              pop;
  logic [DW:0]       head;

  logic [CW-1:0]     idle_cnt;

  assign unused   = &{1'b0, i_icb_cmd_addr[1:0]};
  assign word     = i_icb_cmd_addr[AW-1:2];
  assign in_range = ({1'b0, word} < DP_LIM);

  assign i_icb_cmd_ready = ~rst & ~ram_ls & (occ < 2'd2);
  assign accept = i_icb_cmd_valid & i_icb_cmd_ready;

  assign ram_cs   = accept & in_range;
  assign ram_we   = ~i_icb_cmd_read;
  assign ram_wem  = i_icb_cmd_read ? '0 : i_icb_cmd_wmask;
  assign ram_din  = i_icb_cmd_wdata;
  assign ram_addr = word;
  assign ram_sd   = 1'b0;
  assign ram_ds   = 1'b0;

  // RAM data is only valid for one cycle; the pending slot forwards it
  // straight to the response port and parks it in the buffer if stalled.
  assign pend_data = pend_rd ? ram_dout : '0;
  assign head = (buf_cnt != 2'd0) ? rbuf[rptr] : {pend_data, pend_err};

  assign i_icb_rsp_valid = ~rst & ((buf_cnt != 2'd0) | pend);
  assign i_icb_rsp_rdata = head[DW:1];
  assign i_icb_rsp_err   = head[0];
  assign rsp_hs = i_icb_rsp_valid & i_icb_rsp_ready;

  assign pop  = rsp_hs & (buf_cnt != 2'd0);
  assign push = pend & ~((buf_cnt == 2'd0) & rsp_hs);

  assign idle = (occ == 2'd0) & ~i_icb_cmd_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      occ      <= 2'd0;
      pend     <= 1'b0;
      pend_rd  <= 1'b0;
      pend_err <= 1'b0;
      wptr     <= 1'b0;
      rptr     <= 1'b0;
      buf_cnt  <= 2'd0;
      rbuf[0]  <= '0;
      rbuf[1]  <= '0;
    end else begin
      occ      <= occ + {1'b0, accept} - {1'b0, rsp_hs};
      pend     <= accept;
      pend_rd  <= accept & i_icb_cmd_read & in_range;
      pend_err <= accept & ~in_range;
      if (push) begin
        rbuf[wptr] <= {pend_data, pend_err};
        wptr       <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      buf_cnt <= buf_cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt <= '0;
      ram_ls   <= 1'b0;
    end else begin
      if (!idle) idle_cnt <= '0;
      else if (idle_cnt != LS_MAX) idle_cnt <= idle_cnt + 1'b1;
      if (LS_IDLE == 0) ram_ls <= 1'b0;
      else if (ram_ls & i_icb_cmd_valid) ram_ls <= 1'b0;
      else if (idle & (idle_cnt == LS_MAX)) ram_ls <= 1'b1;
    end
  end

endmodule

// File: tb/tb_e203_dtcm_icb_ctrl.sv
// Directed bench for e203_dtcm_icb_ctrl with a RAM model and an
// in-order response scoreboard.
module tb_e203_dtcm_icb_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_addr;
  logic        cmd_read;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wmask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        ram_sd, ram_ds, ram_ls, ram_cs, ram_we;
  logic [13:0] ram_addr;
  logic [3:0]  ram_wem;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;

  int checks = 0;
  int fails  = 0;

  logic [32:0] q [$];
  logic [31:0] sh [1024];
  logic [31:0] mem [16384];
  logic [31:0] last_rdata;
  logic        last_err;

  always #5 clk = ~clk;

  e203_dtcm_icb_ctrl #(
    .AW(16), .DW(32), .MW(4), .RAM_AW(14), .DP(1024), .LS_IDLE(16)
  ) dut (
    .clk(clk), .rst(rst),
    .i_icb_cmd_valid(cmd_valid), .i_icb_cmd_ready(cmd_ready),
    .i_icb_cmd_addr(cmd_addr), .i_icb_cmd_read(cmd_read),
    .i_icb_cmd_wdata(cmd_wdata), .i_icb_cmd_wmask(cmd_wmask),
    .i_icb_rsp_valid(rsp_valid), .i_icb_rsp_ready(rsp_ready),
    .i_icb_rsp_rdata(rsp_rdata), .i_icb_rsp_err(rsp_err),
    .ram_sd(ram_sd), .ram_ds(ram_ds), .ram_ls(ram_ls),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wem(ram_wem), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_wem[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
      end else begin
        ram_dout <= mem[ram_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Monitor: scoreboard push on accept, compare head every valid cycle.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      if (rsp_valid) begin
        if (q.size() == 0) chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
        else begin
          chk("rsp_data_err", 64'({rsp_rdata, rsp_err}), 64'(q[0]));
          if (rsp_ready) begin
            last_rdata = rsp_rdata;
            last_err   = rsp_err;
            void'(q.pop_front());
          end
        end
      end
      if (cmd_valid && cmd_ready) begin
        logic [13:0] w;
        logic        inr;
        logic [31:0] m;
        w   = cmd_addr[15:2];
        inr = (w < 14'd1024);
        chk("ram_cs", 64'(ram_cs), 64'(inr));
        if (inr) begin
          chk("ram_addr", 64'(ram_addr), 64'(w));
          chk("ram_we", 64'(ram_we), 64'(!cmd_read));
          chk("ram_wem", 64'(ram_wem), 64'(cmd_read ? 4'h0 : cmd_wmask));
        end
        if (!inr) q.push_back({32'h0, 1'b1});
        else if (cmd_read) q.push_back({sh[w[9:0]], 1'b0});
        else begin
          q.push_back(33'h0);
          m = {{8{cmd_wmask[3]}}, {8{cmd_wmask[2]}},
               {8{cmd_wmask[1]}}, {8{cmd_wmask[0]}}};
          sh[w[9:0]] = (sh[w[9:0]] & ~m) | (cmd_wdata & m);
        end
      end
    end
  end

  task automatic drive(input logic rd, input logic [15:0] a,
                       input logic [31:0] d, input logic [3:0] m);
    cmd_valid = 1'b1;
    cmd_read  = rd;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_wmask = m;
  endtask

  task automatic wait_acc();
    bit got = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        got = 1;
        break;
      end
    end
    if (!got) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic issue(input logic rd, input logic [15:0] a,
                       input logic [31:0] d, input logic [3:0] m);
    drive(rd, a, d, m);
    wait_acc();
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !rsp_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("drain_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
    for (int i = 0; i < 1024; i++) sh[i] = 32'h0;
    ram_dout  = 32'h0;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_read  = 1'b0;
    cmd_addr  = 16'h0;
    cmd_wdata = 32'h0;
    cmd_wmask = 4'h0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_ram_ls", 64'(ram_ls), 64'd0);
    chk("ram_sd_ds", 64'({ram_sd, ram_ds}), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Full write then read back, with 1-cycle latency checks.
    issue(1'b0, 16'h0010, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    chk("wr_latency", 64'(rsp_valid), 64'd1);
    @(posedge clk);
    #1;
    issue(1'b1, 16'h0010, 32'h0, 4'h0);
    @(negedge clk);
    chk("rd_latency", 64'(rsp_valid), 64'd1);
    drain();
    chk("rd_full", 64'(last_rdata), 64'hDEADBEEF);

    issue(1'b0, 16'h0010, 32'h11223344, 4'b0101);
    issue(1'b1, 16'h0010, 32'h0, 4'h0);
    drain();
    chk("rd_partial", 64'(last_rdata), 64'hDE22BE44);

    // Back-to-back and backpressure.
    issue(1'b0, 16'h0020, 32'hA0A0A0A0, 4'hF);
    issue(1'b0, 16'h0024, 32'hB1B1B1B1, 4'hF);
    issue(1'b0, 16'h0028, 32'hC2C2C2C2, 4'hF);
    drain();
    rsp_ready = 1'b0;
    issue(1'b1, 16'h0020, 32'h0, 4'h0);
    issue(1'b1, 16'h0024, 32'h0, 4'h0);
    drive(1'b1, 16'h0028, 32'h0, 4'h0);
    repeat (3) begin
      @(negedge clk);
      chk("full_cmd_ready", 64'(cmd_ready), 64'd0);
      chk("stall_rsp_valid", 64'(rsp_valid), 64'd1);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_acc();
    drain();
    chk("third_rd", 64'(last_rdata), 64'hC2C2C2C2);

    // Range boundary: word 1023 ok, word 1024 faults.
    issue(1'b0, 16'h0FFC, 32'h5A5A0001, 4'hF);
    issue(1'b1, 16'h0FFC, 32'h0, 4'h0);
    issue(1'b1, 16'h1000, 32'h0, 4'h0);
    drain();
    chk("oor_err", 64'({last_rdata, last_err}), 64'({32'h0, 1'b1}));
    issue(1'b0, 16'h1004, 32'hFFFFFFFF, 4'hF);
    drain();
    chk("oor_wr_err", 64'(last_err), 64'd1);

    // Light sleep entry and wake-up bubble.
    issue(1'b0, 16'h0030, 32'h12345678, 4'hF);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ram_ls) break;
      n++;
    end
    chk("ls_delay", 64'(n), 64'd18);
    @(posedge clk);
    #1 drive(1'b1, 16'h0030, 32'h0, 4'h0);
    @(negedge clk);
    chk("wake_bubble_ready", 64'(cmd_ready), 64'd0);
    chk("wake_ls_still", 64'(ram_ls), 64'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("wake_ls_clear", 64'(ram_ls), 64'd0);
    chk("wake_ready", 64'(cmd_ready), 64'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    drain();
    chk("wake_rd", 64'(last_rdata), 64'h12345678);

    // Reset with responses buffered.
    rsp_ready = 1'b0;
    issue(1'b1, 16'h0020, 32'h0, 4'h0);
    issue(1'b1, 16'h0024, 32'h0, 4'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("post_rst_ls", 64'(ram_ls), 64'd0);
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    issue(1'b1, 16'h0024, 32'h0, 4'h0);
    drain();
    chk("post_rst_rd", 64'(last_rdata), 64'hB1B1B1B1);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/e203_dtcm_icb_ctrl.md
Name: e203_dtcm_icb_ctrl

Overview:
ICB-to-SRAM controller that sits directly upstream of the DTCM RAM macro wrapper. It accepts single-beat ICB read and write commands from the LSU/biu arbiter and drives the RAM's cs/we/addr/wem/din pins. It captures the RAM's one-cycle-latency read data into a 2-entry response buffer so the response channel tolerates backpressure. It also manages the RAM light-sleep pin from an idle counter.

Parameters:
AW, 16, ICB byte-address width
DW, 32, data width
MW, 4, write-mask width (DW/8)
RAM_AW, 14, RAM word-address width (AW-2)
DP, 16384, implemented RAM depth in words (≤ 2^RAM_AW)
LS_IDLE, 16, idle cycles before ram_ls asserts; 0 disables light sleep

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_icb_cmd_valid  in  1  command valid
i_icb_cmd_ready  out  1  command ready
i_icb_cmd_addr  in  AW  byte address; bits [1:0] ignored
i_icb_cmd_read  in  1  1=read, 0=write
i_icb_cmd_wdata  in  DW  write data
i_icb_cmd_wmask  in  MW  byte write enables
i_icb_rsp_valid  out  1  response valid
i_icb_rsp_ready  in  1  response ready
i_icb_rsp_rdata  out  DW  read data (0 for writes/errors)
i_icb_rsp_err  out  1  access error
ram_sd  out  1  shutdown, tied 0
ram_ds  out  1  deep sleep, tied 0
ram_ls  out  1  light sleep
ram_cs  out  1  RAM chip select
ram_we  out  1  RAM write enable
ram_addr  out  RAM_AW  RAM word address = cmd_addr[AW-1:2]
ram_wem  out  MW  RAM write mask
ram_din  out  DW  RAM write data
ram_dout  in  DW  RAM read data, valid cycle after cs&~we

Behaviour:
- Reset (sync, rst=1 at posedge): occupancy=0, buffer empty, ram_ls=0, idle counter=0; i_icb_rsp_valid=0, i_icb_cmd_ready=0 during reset; in-flight responses discarded.
- Handshake: cmd accepted when valid&ready. cmd_ready = ~rst & ~ram_ls & (occupancy<2). Occupancy = accepted commands whose responses are not yet handed off; +1 on cmd accept, -1 on rsp handshake, both in same cycle → unchanged.
- RAM drive (combinational from accept): ram_cs = accept & in_range; ram_we = ~read; ram_wem = wmask for writes, 0 for reads; ram_din = wdata; ram_addr = addr[AW-1:2].
- in_range = (addr[AW-1:2] < DP). Out-of-range: ram_cs=0, response err=1, rdata=0; still consumes one occupancy slot.
- Response capture: one cycle after accept (cycle N+1), entry {rdata, err} written at buffer tail: reads in range → ram_dout; writes → 0, err=0. Entry then visible.
- i_icb_rsp_valid = head entry written. Minimum latency: accept at N → rsp_valid at N+1. Responses strictly in command order.
- Buffer: 2 entries, circular wptr/rptr; no overflow possible due to occupancy gating. Back-to-back accepts sustain 1 cmd/cycle while rsp_ready=1.
- rsp_valid, once asserted, holds with stable rdata/err until rsp_ready.
- Light sleep: idle = occupancy==0 & ~cmd_valid. Counter increments on idle cycles, saturating at LS_IDLE; cleared on any non-idle cycle. ram_ls rises the cycle after counter reaches LS_IDLE. While ram_ls=1 and cmd_valid=1: ram_ls clears next cycle, cmd_ready=0 that cycle (one wake-up bubble). LS_IDLE=0 → ram_ls permanently 0.
- ram_sd=ram_ds=0 always.

Test Plan:
- Write addr 0x0010 wdata 0xDEADBEEF wmask 4'hF, then read 0x0010 → write rsp err=0 rdata=0 at N+1; read rsp rdata 0xDEADBEEF; ram_addr=4, ram_wem=4'hF on write.
- Partial write wmask 4'b0101 data 0x11223344 over 0xDEADBEEF, read back → rdata 0xDE22BE44.
- rsp_ready=0, issue 3 back-to-back reads → first two accepted, cmd_ready=0 on third until one rsp handshake; responses in order, data stable while stalled.
- DP=1024, read addr 0x1000 (word 1024) → ram_cs never asserts, rsp err=1 rdata=0.
- Idle 16 cycles → ram_ls=1 on the following cycle; then cmd_valid → cmd_ready=0 one cycle, ram_ls=0, command accepted next cycle.
- Assert rst with 2 responses buffered → next cycle rsp_valid=0, occupancy 0, ram_ls=0; new read completes normally.
